// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end: instruction width,
// bytes per instruction and the fetch state encoding.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    // IDLE: no request outstanding (queue full or waiting to start).
    // REQ : request outstanding whose response will be queued.
    // DROP: request outstanding whose response must be discarded (a redirect
    //       arrived while it was in flight).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry queue with push, pop and clear. The head entry is
// read straight out of registered storage, so it is stable until popped.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear_i     drop all entries (wins over push/pop in the same cycle)
//   push_i      write data_i at the tail (ignored when full and not popping)
//   data_i      entry to push
//   pop_i       remove the head entry (ignored when empty)
//   count_o     number of valid entries, 0..DEPTH
//   valid_o     queue is non-empty
//   head_o      head entry
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic [W-1:0]     head_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the storage is reset as well, because the head is visible on the
    // outputs and must read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule : fetch_fifo

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
// Instruction-fetch front end. Owns the PC, issues one request at a time to
// instruction memory over req/ack, and buffers returned words with their PCs
// in a DEPTH-entry queue that decode drains with valid/ready. A redirect
// flushes the queue and squashes any response still in flight.
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   imem_req     request valid, held until imem_ack
//   imem_addr    request address, stable while imem_req=1
//   imem_ack     request accepted and data returned this cycle
//   imem_rdata   returned instruction word (valid with imem_ack)
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new PC, low two bits ignored
//   out_valid    queue head valid
//   out_ready    decode accepts the head
//   out_instr    head instruction
//   out_pc       head instruction's PC
// -----------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int                CNT_W      = $clog2(DEPTH + 1);
    localparam int                ENTRY_W    = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;

    logic               q_push, q_pop, q_valid;
    logic [CNT_W-1:0]   q_count, cnt_after_pop;
    logic [ENTRY_W-1:0] q_head;
    logic [ADDR_W-1:0]  redirect_aligned;

    assign redirect_aligned = redirect_pc & ALIGN_MASK;
    assign q_pop            = q_valid && out_ready;
    // Occupancy once this cycle's pop has gone; decides whether to issue.
    assign cnt_after_pop    = q_count - CNT_W'(q_pop);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        issue_addr_d = issue_addr_q;
        q_push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d   = redirect_aligned;
                    issue_addr_d = redirect_aligned;
                    state_d      = REQ;
                end else if (cnt_after_pop < DEPTH_CNT) begin
                    issue_addr_d = fetch_pc_q;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_aligned;
                    if (imem_ack) begin
                        // Response retires now but is stale; restart at once.
                        issue_addr_d = redirect_aligned;
                    end else begin
                        // Request must stay up at the old address until acked.
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    q_push     = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    if ((cnt_after_pop + CNT_W'(1)) < DEPTH_CNT) begin
                        issue_addr_d = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) fetch_pc_d = redirect_aligned;
                // The queue was flushed on entry, so there is always room.
                if (imem_ack) begin
                    issue_addr_d = fetch_pc_d;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            issue_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            issue_addr_q <= issue_addr_d;
        end
    end

    fetch_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (redirect),
        .push_i  (q_push),
        .data_i  ({fetch_pc_q, imem_rdata}),
        .pop_i   (q_pop),
        .count_o (q_count),
        .valid_o (q_valid),
        .head_o  (q_head)
    );

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = issue_addr_q;
    assign out_valid = q_valid;
    assign out_pc    = q_head[ENTRY_W-1:INSTR_W];
    assign out_instr = q_head[INSTR_W-1:0];

endmodule : fetch_queue_unit

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    localparam int ADDR_W = 64;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;

    fetch_queue_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    typedef struct {
        logic        ack;
        logic        ready;
        logic        redir;
        logic [63:0] rpc;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic r, input logic d, input logic [63:0] rp,
                                input logic er, input logic [63:0] ea, input logic ev, input logic [63:0] ep);
        vec_t v;
        v.ack = a; v.ready = r; v.redir = d; v.rpc = rp;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    task automatic drive(input logic a, input logic r, input logic d, input logic [63:0] rp);
        imem_ack    = a;
        out_ready   = r;
        redirect    = d;
        redirect_pc = rp;
        imem_rdata  = mem_word(imem_addr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req"},   64'(imem_req),  64'd0);
        check({tag, " addr"},  imem_addr,      64'd0);
        check({tag, " valid"}, 64'(out_valid), 64'd0);
        check({tag, " instr"}, 64'(out_instr), 64'd0);
        check({tag, " pc"},    out_pc,         64'd0);
    endtask

    vec_t        vecs[$];
    ent_t        mq[$];
    logic [63:0] top_pc;
    logic [63:0] exp_pc, prev_addr, rpc;
    logic        stale, prev_req, prev_ack, r_ack, r_ready, r_redir;
    int          pops;

    initial begin
        top_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        // ack ready redir rpc       | req addr     valid pc
        vecs.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, 4,      1, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, 8,      1, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, 12,     1, 0));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0,      1, 0));
        vecs.push_back(mk(0, 0, 0, 0,      1, 16,     1, 4));
        vecs.push_back(mk(1, 0, 0, 0,      1, 16,     1, 4));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0,      1, 4));
        vecs.push_back(mk(0, 0, 1, 'h103,  1, 20,     1, 8));
        vecs.push_back(mk(1, 0, 0, 0,      1, 20,     0, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, 'h100,  0, 0));
        vecs.push_back(mk(1, 0, 1, 'h200,  1, 'h104,  1, 'h100));
        vecs.push_back(mk(0, 1, 0, 0,      1, 'h200,  0, 0));
        vecs.push_back(mk(1, 1, 0, 0,      1, 'h200,  0, 0));
        vecs.push_back(mk(1, 1, 0, 0,      1, 'h204,  1, 'h200));
        vecs.push_back(mk(0, 1, 1, top_pc, 1, 'h208,  1, 'h204));
        vecs.push_back(mk(0, 0, 0, 0,      1, 'h208,  0, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, 'h208,  0, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, top_pc, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,      1, 0,      1, top_pc));
        vecs.push_back(mk(0, 1, 0, 0,      1, 4,      1, top_pc));
        vecs.push_back(mk(0, 0, 0, 0,      1, 4,      1, 0));

        reset = 1'b0;
        drive(0, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("in_reset");
        @(negedge clk);
        reset = 1'b1;

        // Directed table: fill, stall, redirects, same-cycle ack+redirect, wrap.
        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("v%0d req", i), 64'(imem_req), 64'(vecs[i].exp_req));
            if (vecs[i].exp_req) check($sformatf("v%0d addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d pc", i), out_pc, vecs[i].exp_pc);
                check($sformatf("v%0d instr", i), 64'(out_instr), 64'(mem_word(vecs[i].exp_pc)));
            end
            drive(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a request with two words queued.
        drive(1, 0, 0, '0);
        @(posedge clk); #1;
        drive(0, 0, 0, '0);
        @(posedge clk); #1;
        check("pre_rst req", 64'(imem_req), 64'd1);
        check("pre_rst addr", imem_addr, 64'd8);
        check("pre_rst pc", out_pc, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 0, '0);  // late ack while imem_req=0
        @(posedge clk); #1;
        check("post_rst req", 64'(imem_req), 64'd1);
        check("post_rst addr", imem_addr, 64'd0);
        check("post_rst late_ack_ignored", 64'(out_valid), 64'd0);
        drive(1, 0, 0, '0);
        @(posedge clk); #1;
        check("post_rst valid", 64'(out_valid), 64'd1);
        check("post_rst pc", out_pc, 64'd0);
        check("post_rst instr", 64'(out_instr), 64'(mem_word(64'd0)));

        // Randomised run against a transaction-level model: an acked word is
        // kept only if no redirect was seen since its request began; kept
        // words carry consecutive PCs from the last redirect target.
        drive(0, 0, 0, '0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        exp_pc = '0; stale = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; pops = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            check("rnd valid", 64'(out_valid), 64'(mq.size() != 0));
            if (out_valid && mq.size() != 0) begin
                check("rnd pc", out_pc, mq[0].pc);
                check("rnd instr", 64'(out_instr), 64'(mq[0].instr));
            end
            if (mq.size() == DEPTH) check("rnd full_no_req", 64'(imem_req), 64'd0);
            if (prev_req && !prev_ack) begin
                check("rnd req_held", 64'(imem_req), 64'd1);
                check("rnd addr_stable", imem_addr, prev_addr);
            end
            if (imem_req && (!prev_req || prev_ack)) stale = 1'b0;

            r_ack   = imem_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            r_ready = ($urandom_range(0, 9) < 7);
            r_redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) rpc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            else                           rpc = {32'h0, 16'h0, 16'($urandom)};
            drive(r_ack, r_ready, r_redir, rpc);

            if (r_redir) begin
                mq.delete();
                exp_pc = rpc & ~64'd3;
                stale  = 1'b1;
            end else begin
                if (out_valid && r_ready && mq.size() != 0) begin
                    void'(mq.pop_front());
                    pops++;
                end
                if (r_ack && imem_req && !stale) begin
                    check("rnd issue_addr", imem_addr, exp_pc);
                    mq.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
                    exp_pc = exp_pc + 64'd4;
                end
            end
            prev_req  = imem_req;
            prev_ack  = r_ack && imem_req;
            prev_addr = imem_addr;
            @(posedge clk);
            #1;
        end
        check("rnd progress", 64'(pops > 500), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_queue_unit
